// File: rtl/ppwm_pkg.sv
// Shared types and defaults for the serial program transmitter.
package ppwm_pkg;

  localparam int unsigned PPWM_INSTR_WIDTH = 7;
  localparam int unsigned PPWM_DEPTH       = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WORD = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4,
    DONE      = 3'd5
  } ppwm_state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ppwm_bit_tick.sv
// Bit-period divider: tick_o marks the last cycle of each bit while enabled.
module ppwm_bit_tick
  import ppwm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned DIV_W = cnt_width(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Restart the period whenever the divider is idle or wraps.
  always_comb begin
    div_d = div_q;
    if (!en_i || (div_q == DIV_LAST)) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick_o = en_i && (div_q == DIV_LAST);

endmodule

// File: rtl/ppwm_prog_tx.sv
// Serialises a program of DEPTH instruction words onto a framed, MSB-first line.
module ppwm_prog_tx
  import ppwm_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH  = PPWM_INSTR_WIDTH,
  parameter int unsigned DEPTH        = PPWM_DEPTH,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [INSTR_WIDTH-1:0] word_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   serial_o
);

  localparam int unsigned WCNT_W = $clog2(DEPTH + 1);
  localparam int unsigned BCNT_W = cnt_width(INSTR_WIDTH);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DEPTH);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(INSTR_WIDTH - 1);

  ppwm_state_e            state_q;
  ppwm_state_e            state_d;
  logic [INSTR_WIDTH-1:0] shift_q;
  logic [INSTR_WIDTH-1:0] shift_d;
  logic [BCNT_W-1:0]      bit_cnt_q;
  logic [BCNT_W-1:0]      bit_cnt_d;
  logic [WCNT_W-1:0]      word_cnt_q;
  logic [WCNT_W-1:0]      word_cnt_d;
  logic [WCNT_W-1:0]      word_cnt_inc;
  logic                   serial_d;
  logic                   busy_d;
  logic                   ready_d;
  logic                   done_d;
  logic                   tick_en;
  logic                   tick;

  assign tick_en = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  ppwm_bit_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_cnt_inc = word_cnt_q + WCNT_W'(1);
    serial_d     = 1'b0;
    busy_d       = 1'b0;
    ready_d      = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = WAIT_WORD;
          word_cnt_d = '0;
        end
      end
      WAIT_WORD: begin
        if (word_ready_o && word_valid_i) begin
          shift_d   = word_i;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (bit_cnt_q == BCNT_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          word_cnt_d = word_cnt_inc;
          state_d    = (word_cnt_inc == WCNT_LAST) ? DONE : WAIT_WORD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it.
    case (state_d)
      WAIT_WORD: begin
        busy_d  = 1'b1;
        ready_d = 1'b1;
      end
      START: begin
        busy_d   = 1'b1;
        serial_d = 1'b1;
      end
      DATA: begin
        busy_d   = 1'b1;
        serial_d = shift_d[INSTR_WIDTH-1];
      end
      STOP: begin
        busy_d = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      serial_o     <= 1'b0;
      busy_o       <= 1'b0;
      word_ready_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      serial_o     <= serial_d;
      busy_o       <= busy_d;
      word_ready_o <= ready_d;
      done_o       <= done_d;
    end
  end

endmodule

// File: tb/tb_ppwm_prog_tx.sv
// Bench for ppwm_prog_tx: vector tables, directed corner sequences and a queue-based reference model.
module tb_ppwm_prog_tx;

  localparam int unsigned IW      = 7;
  localparam int unsigned CPB     = 4;
  localparam int unsigned DEPTH_B = 16;
  localparam int unsigned FRAME   = (IW + 2) * CPB;

  typedef struct {
    logic          start;
    logic          valid;
    logic [IW-1:0] word;
    logic [3:0]    exp;   // {serial, busy, ready, done}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sa = 0, va = 0, ra, ba, da, qa;
  logic sb = 0, vb = 0, rb, bb, db, qb;
  logic sc = 0, vc = 0, rc, bc, dc, qc;
  logic [IW-1:0] wa = '0, wb = '0, wc = '0;

  ppwm_prog_tx #(.INSTR_WIDTH(IW), .DEPTH(1), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .rst(rst), .start_i(sa), .word_i(wa), .word_valid_i(va),
    .word_ready_o(ra), .busy_o(ba), .done_o(da), .serial_o(qa));

  ppwm_prog_tx #(.INSTR_WIDTH(IW), .DEPTH(DEPTH_B), .CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .rst(rst), .start_i(sb), .word_i(wb), .word_valid_i(vb),
    .word_ready_o(rb), .busy_o(bb), .done_o(db), .serial_o(qb));

  ppwm_prog_tx #(.INSTR_WIDTH(IW), .DEPTH(1), .CLKS_PER_BIT(1)) dut_c (
    .clk(clk), .rst(rst), .start_i(sc), .word_i(wc), .word_valid_i(vc),
    .word_ready_o(rc), .busy_o(bc), .done_o(dc), .serial_o(qc));

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  acc_b;
  bit  exp_a [9] = '{1, 1, 0, 1, 0, 1, 0, 1, 0};
  vec_t tab_a[$];
  vec_t tab_c[$];

  // Reference model of dut_b: the remaining frame bits, one entry per cycle.
  bit m_q[$];
  bit m_busy, m_done;
  int m_words;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] m_exp();
    logic s;
    s = (m_q.size() != 0) ? m_q[0] : 1'b0;
    return {s, m_busy, m_busy && (m_q.size() == 0), m_done};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy  = 0;
    m_done  = 0;
    m_words = 0;
  endtask

  task automatic apply_vec(input int which, input vec_t v, input string name);
    logic [3:0] got;
    if (which == 0) begin sa = v.start; va = v.valid; wa = v.word; end
    else begin sc = v.start; vc = v.valid; wc = v.word; end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    got = (which == 0) ? {qa, ba, ra, da} : {qc, bc, rc, dc};
    chk(name, 32'(got), 32'(v.exp));
  endtask

  task automatic step_b(input logic s, input logic v, input logic [IW-1:0] w);
    logic [IW+1:0] fr;
    sb = s; vb = v; wb = w;
    acc_b = rb && v;
    @(posedge clk);
    if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (s) begin m_busy = 1; m_words = 0; end
    end else if (m_q.size() == 0) begin
      if (v) begin
        fr = {1'b1, w, 1'b0};
        for (int b = IW + 1; b >= 0; b--)
          for (int c = 0; c < int'(CPB); c++) m_q.push_back(fr[b]);
        m_words++;
      end
    end else begin
      void'(m_q.pop_front());
      if (m_q.size() == 0 && m_words == int'(DEPTH_B)) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    @(negedge clk);
    cyc++;
    chk("b_outputs", 32'({qb, bb, rb, db}), 32'(m_exp()));
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    sa = 0; va = 0; sb = 0; vb = 0; sc = 0; vc = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int last;

    tab_a.push_back('{start: 1'b1, valid: 1'b0, word: 7'h00, exp: 4'b0110});
    for (int k = 0; k < int'(FRAME); k++)
      tab_a.push_back('{start: 1'b0, valid: (k == 0), word: (k == 0) ? 7'h55 : 7'h00,
                        exp: {exp_a[k / int'(CPB)], 3'b100}});
    tab_a.push_back('{start: 1'b0, valid: 1'b0, word: 7'h00, exp: 4'b0001});
    tab_a.push_back('{start: 1'b0, valid: 1'b0, word: 7'h00, exp: 4'b0000});

    tab_c.push_back('{start: 1'b1, valid: 1'b0, word: 7'h00, exp: 4'b0110});
    for (int k = 0; k < 9; k++)
      tab_c.push_back('{start: 1'b0, valid: (k == 0), word: (k == 0) ? 7'h7F : 7'h00,
                        exp: {(k < 8), 3'b100}});
    tab_c.push_back('{start: 1'b0, valid: 1'b0, word: 7'h00, exp: 4'b0001});
    tab_c.push_back('{start: 1'b0, valid: 1'b0, word: 7'h00, exp: 4'b0000});

    model_reset();
    #1;
    chk("rst_a", 32'({qa, ba, ra, da}), 32'h0);
    chk("rst_b", 32'({qb, bb, rb, db}), 32'h0);
    chk("rst_c", 32'({qc, bc, rc, dc}), 32'h0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Single frame, word 0x55, four clocks per bit.
    for (int i = 0; i < tab_a.size(); i++) apply_vec(0, tab_a[i], $sformatf("a_vec%0d", i));
    // Minimum divider, word 0x7F.
    for (int i = 0; i < tab_c.size(); i++) apply_vec(1, tab_c[i], $sformatf("c_vec%0d", i));

    // Back-to-back words with a source that is always valid.
    do_reset();
    step_b(1, 0, '0);
    n = 0; last = 0;
    for (int i = 0; i < 1000 && n < int'(DEPTH_B); i++) begin
      step_b(0, 1, IW'($urandom));
      if (acc_b) begin
        if (n > 0) chk("b2b_spacing", 32'(cyc - last), 32'(FRAME + 1));
        last = cyc;
        n++;
      end
    end
    chk("b2b_words", 32'(n), 32'(DEPTH_B));
    for (int i = 0; i < 100 && !db; i++) step_b(0, 1, IW'($urandom));
    chk("done_latency", 32'(cyc - last), 32'(FRAME));

    // Stalled source between words 3 and 4.
    do_reset();
    step_b(1, 0, '0);
    n = 0;
    for (int i = 0; i < 500 && n < 3; i++) begin
      step_b(0, 1, IW'($urandom));
      if (acc_b) n++;
    end
    for (int i = 0; i < 100 && !rb; i++) step_b(0, 0, '0);
    for (int i = 0; i < 50; i++) begin
      step_b(0, 0, '0);
      chk("stall_gap", 32'({qb, bb, rb}), 32'(3'b011));
    end
    for (int i = 0; i < 1500 && !db; i++) begin
      step_b(0, 1, IW'($urandom));
      if (acc_b) n++;
    end
    chk("stall_words", 32'(n), 32'(DEPTH_B));
    chk("stall_done", 32'(db), 32'h1);

    // Reset during data bit 2.
    do_reset();
    step_b(1, 0, '0);
    step_b(0, 1, 7'h7F);
    chk("rst_mid_accept", 32'(acc_b), 32'h1);
    repeat (13) step_b(0, 0, '0);
    chk("pre_rst_serial", 32'({qb, bb}), 32'(2'b11));
    #2 rst = 1;
    #1;
    chk("rst_async", 32'({qb, bb, rb, db}), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) step_b(0, 0, '0);
    chk("post_rst_idle", 32'({qb, bb, rb, db}), 32'h0);

    // Spurious starts in DATA and in DONE.
    do_reset();
    step_b(1, 0, '0);
    step_b(0, 1, IW'($urandom));
    repeat (6) step_b(0, 0, '0);
    step_b(1, 0, '0);
    for (int i = 0; i < 1500 && !db; i++) step_b(0, 1, IW'($urandom));
    chk("spur_done_seen", 32'(db), 32'h1);
    step_b(1, 0, '0);
    chk("spur_done_ignored", 32'({bb, rb, db}), 32'h0);
    step_b(1, 0, '0);
    chk("restart", 32'({bb, rb}), 32'(2'b11));
    n = 0;
    for (int i = 0; i < 1500 && !db; i++) begin
      step_b(0, 1, IW'($urandom));
      if (acc_b) n++;
    end
    chk("restart_words", 32'(n), 32'(DEPTH_B));

    // Randomised traffic against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++)
      step_b($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, IW'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
